// File: rtl/vid_sync_polarity_normaliser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vid_sync_polarity_normaliser_pkg
// Purpose  : Shared constants and helpers for the video sync polarity
//            normaliser (channel limits, counter sizing, channel indices).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package vid_sync_polarity_normaliser_pkg;

    localparam int MAX_SYNC       = 8;
    localparam int MAX_LOCK_COUNT = 15;

    // Conventional channel assignment on the sync_in bus.
    localparam int CH_HSYNC = 0;
    localparam int CH_VSYNC = 1;
    localparam int CH_FIELD = 2;

    // Counters must hold the value LOCK_COUNT itself.
    function automatic int cnt_width(input int lock_count);
        return $clog2(lock_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vid_sync_polarity_normaliser_sync_pol_channel.sv
`default_nettype none
// ============================================================================
// Module   : sync_pol_channel
// Purpose  : Polarity detector for one sync channel. Records whether the sync
//            was high anywhere inside a datavalid window and, on the window's
//            falling edge, votes on the channel's inversion with hysteresis.
// Ports    : clk, rst (async, active-high)
//            datavalid  - active-video qualifier
//            dv_fall    - shared falling-edge strobe of datavalid
//            sync_in    - this channel's raw sync level
//            inv        - detected inversion (registered)
//            locked     - detected polarity stable for LOCK_COUNT evaluations
// Revision : 1.0 - initial release
// ============================================================================
module sync_pol_channel
    import vid_sync_polarity_normaliser_pkg::*;
#(
    parameter int LOCK_COUNT = 2,
    parameter int CW         = cnt_width(LOCK_COUNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic datavalid,
    input  logic dv_fall,
    input  logic sync_in,
    output logic inv,
    output logic locked
);

    localparam logic [CW-1:0] c_lock = CW'(LOCK_COUNT);

    logic          r_seen;
    logic          r_inv;
    logic          r_locked;
    logic [CW-1:0] r_agree;
    logic [CW-1:0] r_mis;

    logic          w_cand;
    logic [CW-1:0] w_agree_inc;
    logic [CW-1:0] w_mis_inc;

    // A sync that was active during the window means the pin idles low in
    // blanking relative to it, i.e. the raw signal is active-low.
    assign w_cand      = r_seen | (datavalid & sync_in);
    assign w_agree_inc = (r_agree == c_lock) ? r_agree : r_agree + CW'(1);
    // r_mis never rests at LOCK_COUNT (it clears on the toggle), so no wrap.
    assign w_mis_inc   = r_mis + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seen   <= 1'b0;
            r_inv    <= 1'b0;
            r_locked <= 1'b0;
            r_agree  <= '0;
            r_mis    <= '0;
        end else begin
            if (dv_fall) begin
                r_seen <= 1'b0;
            end else if (datavalid & sync_in) begin
                r_seen <= 1'b1;
            end

            if (dv_fall) begin
                if (w_cand == r_inv) begin
                    r_mis   <= '0;
                    r_agree <= w_agree_inc;
                    if (w_agree_inc == c_lock) begin
                        r_locked <= 1'b1;
                    end
                end else begin
                    r_locked <= 1'b0;
                    if (w_mis_inc == c_lock) begin
                        // The toggling evaluation itself counts as the first
                        // agreement with the new polarity.
                        r_inv   <= ~r_inv;
                        r_mis   <= '0;
                        r_agree <= CW'(1);
                    end else begin
                        r_mis   <= w_mis_inc;
                        r_agree <= '0;
                    end
                end
            end
        end
    end

    assign inv    = r_inv;
    assign locked = r_locked;

endmodule
`default_nettype wire

// File: rtl/vid_sync_polarity_normaliser.sv
`default_nettype none
// ============================================================================
// Module   : vid_sync_polarity_normaliser
// Purpose  : Presents every sync channel active-high downstream. Polarity is
//            inferred per channel from its level inside the datavalid window,
//            with hysteresis, lock status and a software override.
// Ports    : clk, rst (async, active-high)
//            datavalid     - active-video qualifier
//            sync_in       - raw sync levels, bit i = channel i
//            force_en      - use force_invert instead of detected polarity
//            force_invert  - per-channel override inversion
//            sync_out      - normalised syncs
//            invert_status - detected inversion per channel
//            locked        - detected polarity stable per channel
// Config   : SYNC_POL_OUT_REG_EN - register sync_out (one cycle latency,
//            reset value 0); otherwise sync_out is combinational.
// Revision : 1.0 - initial release
// ============================================================================
module vid_sync_polarity_normaliser
    import vid_sync_polarity_normaliser_pkg::*;
#(
    parameter int NUM_SYNC   = 2,
    parameter int LOCK_COUNT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                datavalid,
    input  logic [NUM_SYNC-1:0] sync_in,
    input  logic                force_en,
    input  logic [NUM_SYNC-1:0] force_invert,
    output logic [NUM_SYNC-1:0] sync_out,
    output logic [NUM_SYNC-1:0] invert_status,
    output logic [NUM_SYNC-1:0] locked
);

    localparam int c_cw = cnt_width(LOCK_COUNT);

    logic                r_dv;
    logic                w_dv_fall;
    logic [NUM_SYNC-1:0] w_inv;
    logic [NUM_SYNC-1:0] w_eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dv <= 1'b0;
        end else begin
            r_dv <= datavalid;
        end
    end

    assign w_dv_fall = r_dv & ~datavalid;

    for (genvar i = 0; i < NUM_SYNC; i++) begin : g_ch
        sync_pol_channel #(
            .LOCK_COUNT (LOCK_COUNT),
            .CW         (c_cw)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .datavalid (datavalid),
            .dv_fall   (w_dv_fall),
            .sync_in   (sync_in[i]),
            .inv       (w_inv[i]),
            .locked    (locked[i])
        );
    end

    // The override only steers the output; status always reflects detection.
    assign w_eff         = force_en ? force_invert : w_inv;
    assign invert_status = w_inv;

`ifdef SYNC_POL_OUT_REG_EN
    logic [NUM_SYNC-1:0] r_sync_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_out <= '0;
        end else begin
            r_sync_out <= sync_in ^ w_eff;
        end
    end

    assign sync_out = r_sync_out;
`else
    assign sync_out = sync_in ^ w_eff;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vid_sync_polarity_normaliser.sv
`default_nettype none
// ============================================================================
// Module   : tb_vid_sync_polarity_normaliser
// Purpose  : Self-checking bench for vid_sync_polarity_normaliser. Stimulus
//            pushes the expected outputs of each cycle into a queue; a monitor
//            on the falling clock edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vid_sync_polarity_normaliser;

    localparam int NS = 2;
    localparam int LC = 2;
`ifdef SYNC_POL_OUT_REG_EN
    localparam bit OUT_REG = 1'b1;
`else
    localparam bit OUT_REG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          datavalid;
    logic [NS-1:0] sync_in;
    logic          force_en;
    logic [NS-1:0] force_invert;
    logic [NS-1:0] sync_out;
    logic [NS-1:0] invert_status;
    logic [NS-1:0] locked;

    always #5 clk = ~clk;

    vid_sync_polarity_normaliser #(
        .NUM_SYNC   (NS),
        .LOCK_COUNT (LC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .datavalid     (datavalid),
        .sync_in       (sync_in),
        .force_en      (force_en),
        .force_invert  (force_invert),
        .sync_out      (sync_out),
        .invert_status (invert_status),
        .locked        (locked)
    );

    typedef struct packed {
        logic [NS-1:0] so;
        logic [NS-1:0] inv;
        logic [NS-1:0] lk;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: one vote per datavalid window per channel.
    logic [NS-1:0] m_inv;
    logic [NS-1:0] m_locked;
    logic [NS-1:0] m_hit;      // sync observed high somewhere in this window
    int            m_agree[NS];
    int            m_mis[NS];
    logic          m_prev_dv;
    logic [NS-1:0] m_out;      // registered-output variant only

    task automatic model_reset();
        m_inv     = '0;
        m_locked  = '0;
        m_hit     = '0;
        m_prev_dv = 1'b0;
        m_out     = '0;
        for (int i = 0; i < NS; i++) begin
            m_agree[i] = 0;
            m_mis[i]   = 0;
        end
    endtask

    task automatic model_vote(input int i, input logic cand);
        if (cand == m_inv[i]) begin
            m_mis[i]   = 0;
            m_agree[i] = (m_agree[i] + 1 > LC) ? LC : m_agree[i] + 1;
            if (m_agree[i] == LC) m_locked[i] = 1'b1;
        end else begin
            m_agree[i]  = 0;
            m_locked[i] = 1'b0;
            m_mis[i]    = m_mis[i] + 1;
            if (m_mis[i] == LC) begin
                m_inv[i]   = ~m_inv[i];
                m_mis[i]   = 0;
                m_agree[i] = 1;
            end
        end
    endtask

    // Drive one clock cycle of inputs (called #1 after a rising edge).
    task automatic cycle(input logic r, input logic dv, input logic [NS-1:0] s,
                         input logic fe, input logic [NS-1:0] fi);
        logic [NS-1:0] eff;
        exp_t          e;
        rst          = r;
        datavalid    = dv;
        sync_in      = s;
        force_en     = fe;
        force_invert = fi;
        if (r) model_reset();
        eff   = fe ? fi : m_inv;
        e.so  = OUT_REG ? m_out : (s ^ eff);
        e.inv = m_inv;
        e.lk  = m_locked;
        q.push_back(e);
        @(posedge clk);
        if (!r) begin
            m_out = s ^ eff;
            if (m_prev_dv && !dv) begin
                for (int i = 0; i < NS; i++) model_vote(i, m_hit[i]);
                m_hit = '0;
            end else begin
                m_hit = m_hit | (dv ? s : '0);
            end
            m_prev_dv = dv;
        end
        #1;
    endtask

    // One video line: active part with act_lvl on the syncs, then blanking
    // where every sync takes the opposite level for a few cycles.
    task automatic line(input int act, input int blank, input logic [NS-1:0] act_lvl,
                        input logic fe, input logic [NS-1:0] fi);
        for (int k = 0; k < act; k++) cycle(1'b0, 1'b1, act_lvl, fe, fi);
        for (int k = 0; k < blank; k++)
            cycle(1'b0, 1'b0, (k >= 1 && k < blank - 1) ? ~act_lvl : act_lvl, fe, fi);
    endtask

    // Monitor
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_tests++;
            if (sync_out !== e.so || invert_status !== e.inv || locked !== e.lk) begin
                n_fail++;
                $display("FAIL outputs t=%0t: sync_out=%b inv=%b locked=%b, required sync_out=%b inv=%b locked=%b",
                         $time, sync_out, invert_status, locked, e.so, e.inv, e.lk);
            end
        end
    end

    initial begin
        logic [NS-1:0] pol;
        logic [NS-1:0] lvl;
        logic          fe;
        logic [NS-1:0] fi;
        int            act;
        int            blank;

        model_reset();
        rst = 1'b1; datavalid = 1'b0; sync_in = '0; force_en = 1'b0; force_invert = '0;
        @(posedge clk); #1;

        // Reset state, with sync_in wiggling so the passthrough is visible.
        cycle(1'b1, 1'b0, 2'b01, 1'b0, 2'b00);
        cycle(1'b1, 1'b1, 2'b11, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b10, 1'b0, 2'b00);

        // Active-high hsync: low whenever datavalid is high.
        for (int n = 0; n < 4; n++) line(6, 5, 2'b00, 1'b0, 2'b00);

        // Active-low hsync: high during datavalid, flips after two windows.
        for (int n = 0; n < 4; n++) line(6, 5, 2'b01, 1'b0, 2'b00);

        // One glitch line, then steady active-low again.
        line(6, 5, 2'b00, 1'b0, 2'b00);
        for (int n = 0; n < 3; n++) line(6, 5, 2'b01, 1'b0, 2'b00);

        // Software override on channel 1 while detection keeps running.
        for (int n = 0; n < 3; n++) line(6, 5, 2'b01, 1'b1, 2'b10);

        // Reset pulse in mid-window after inversion is detected.
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 2'b01, 1'b0, 2'b00);
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        cycle(1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        cycle(1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
        for (int n = 0; n < 3; n++) line(6, 5, 2'b01, 1'b0, 2'b00);

        // Stuck datavalid: no evaluation in either level.
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 2'(k), 1'b0, 2'b00);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 2'(k), 1'b0, 2'b00);

        // Randomised lines: sticky per-channel polarity with occasional flips,
        // glitches, partial-window syncs, overrides and rare resets.
        pol = 2'b10;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) pol[$urandom_range(0, NS - 1)] ^= 1'b1;
            fe    = ($urandom_range(0, 3) == 0);
            fi    = NS'($urandom);
            act   = $urandom_range(1, 8);
            blank = $urandom_range(1, 6);
            for (int k = 0; k < act; k++) begin
                lvl = pol & NS'($urandom);
                if ($urandom_range(0, 15) == 0) lvl = ~lvl;
                cycle(1'b0, 1'b1, lvl, fe, fi);
            end
            for (int k = 0; k < blank; k++) begin
                if ($urandom_range(0, 4) == 0) fe = ~fe;
                cycle(($urandom_range(0, 60) == 0), 1'b0, NS'($urandom), fe, fi);
            end
        end

        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        @(negedge clk); #1;
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
